img_stream_loader: RTL and testbench

//  Upstream stage of the image pipeline. Accepts a raster-order 24-bit RGB pixel stream (valid/ready) and writes it

---
 rtl/img_stream_loader_pkg.sv | 18 +
 rtl/img_stream_loader_if.sv | 12 +
 rtl/img_stream_loader_raster_counter.sv | 35 +++
 rtl/img_stream_loader.sv | 118 +++++++++++
 tb/tb_img_stream_loader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_stream_loader_pkg.sv
// Shared image geometry and loader FSM encoding for the image pipeline.
// Imported by the loader, its raster counter and the stream interface.
package img_stream_loader_pkg;

  localparam int IMG_W  = 64;
  localparam int IMG_H  = 64;
  localparam int PIX_W  = 24;
  localparam int ADDR_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOF = 3'd1,
    ST_LOAD     = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERR      = 3'd4
  } state_e;

endpackage

// File: rtl/img_stream_loader_if.sv
// Raster pixel stream into the loader.
// A beat transfers on a rising clk edge where s_valid && s_ready; the source holds s_data/s_sof/s_eol while s_valid && !s_ready.
interface img_stream_loader_if;
  logic                                   s_valid;
  logic                                   s_ready;
  logic [img_stream_loader_pkg::PIX_W-1:0] s_data;
  logic                                   s_sof;
  logic                                   s_eol;

  modport master (output s_valid, s_data, s_sof, s_eol, input s_ready);
  modport slave  (input s_valid, s_data, s_sof, s_eol, output s_ready);
endinterface

// File: rtl/img_stream_loader_raster_counter.sv
// Row/column raster position counter with end-of-row and end-of-frame flags.
module raster_counter
  import img_stream_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] r,
  output logic [ADDR_W-1:0] c,
  output logic              last_col,
  output logic              last_pix
);

  assign last_col = (c == ADDR_W'(IMG_W - 1));
  assign last_pix = last_col && (r == ADDR_W'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      c <= '0;
    end else if (clr) begin
      r <= '0;
      c <= '0;
    end else if (inc) begin
      if (last_col) begin
        c <= '0;
        r <= r + 1'b1;
      end else begin
        c <= c + 1'b1;
      end
    end
  end

endmodule

// File: rtl/img_stream_loader.sv
// Writes a framed raster RGB stream into the 64x64 input image RAM and flags completion/framing errors.
// Optional LOADER_CHECKSUM_EN builds a 32-bit running sum of written pixels on the checksum port.
module img_stream_loader
  import img_stream_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  img_stream_loader_if.slave s,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              out_we,
  output logic [PIX_W-1:0]  out_pix,
  output logic              load_done,
  output logic              frame_err,
  output logic [31:0]       checksum,
  output state_e            state_dbg
);

  state_e            state_q, state_d;
  logic              accept, wr, cnt_inc, cnt_clr, set_err;
  logic [ADDR_W-1:0] r, c;
  logic              last_col, last_pix;

  raster_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .r        (r),
    .c        (c),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  assign s.s_ready = ((state_q == ST_WAIT_SOF) || (state_q == ST_LOAD) || (state_q == ST_ERR)) && !arm;
  assign accept    = s.s_valid && s.s_ready;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Counters are cleared on entry to ERR so the resync sof beat lands at (0,0).
  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    set_err = 1'b0;
    if (arm) begin
      state_d = ST_WAIT_SOF;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_WAIT_SOF, ST_ERR: begin
          if (accept && s.s_sof) begin
            wr      = 1'b1;
            cnt_inc = 1'b1;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (s.s_sof || (s.s_eol != last_col)) begin
              set_err = 1'b1;
              cnt_clr = 1'b1;
              state_d = ST_ERR;
            end else begin
              wr = 1'b1;
              if (last_pix) begin
                cnt_clr = 1'b1;
                state_d = ST_DONE;
              end else begin
                cnt_inc = 1'b1;
              end
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_we    <= 1'b0;
      row       <= '0;
      col       <= '0;
      out_pix   <= '0;
      load_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_we    <= wr;
      if (wr) begin
        row     <= r;
        col     <= c;
        out_pix <= s.s_data;
      end
      load_done <= (state_d == ST_DONE);
      frame_err <= arm ? 1'b0 : (frame_err || set_err);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   checksum <= '0;
    else if (arm) checksum <= '0;
    else if (wr)  checksum <= checksum + {8'b0, s.s_data};
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_img_stream_loader.sv
// Directed bench for img_stream_loader: full frames, random valid gaps, framing error, mid-frame arm/reset, checksum.
module tb_img_stream_loader;
  import img_stream_loader_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm = 1'b0;
  logic [ADDR_W-1:0] row, col;
  logic              out_we;
  logic [PIX_W-1:0]  out_pix;
  logic              load_done, frame_err;
  logic [31:0]       checksum;
  state_e            state_dbg;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int spurious = 0;
  logic last_hs = 1'b0;
  logic [PIX_W-1:0] ram_m [0:63][0:63];

  img_stream_loader_if sif();

  img_stream_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .s         (sif.slave),
    .row       (row),
    .col       (col),
    .out_we    (out_we),
    .out_pix   (out_pix),
    .load_done (load_done),
    .frame_err (frame_err),
    .checksum  (checksum),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM model fed from the write port, sampled on the falling edge
  always @(negedge clk) begin
    if (out_we) begin
      ram_m[row][col] = out_pix;
      wr_cnt++;
      if (!last_hs) spurious++;
    end
    last_hs = 1'b0;
  end

  function automatic logic [23:0] pix(input int r, input int c);
    logic [7:0] rr, cc;
    rr = r[7:0];
    cc = c[7:0];
    return {rr, cc, 8'h5A};
  endfunction

  function automatic int ram_mismatches(input bit ff);
    int n;
    logic [23:0] e;
    n = 0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) begin
        e = ff ? 24'hFFFFFF : pix(r, c);
        if (ram_m[r][c] !== e) n++;
      end
    return n;
  endfunction

  task automatic clear_ram();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) ram_m[r][c] = '0;
    wr_cnt = 0;
    spurious = 0;
  endtask

  // driver tasks
  task automatic send_beat(input logic [23:0] d, input logic sof, input logic eol);
    int waited;
    logic hs;
    waited = 0;
    @(negedge clk);
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_sof   = sof;
    sif.s_eol   = eol;
    forever begin
      #1 hs = sif.s_ready;
      @(posedge clk);
      if (hs) begin
        last_hs = 1'b1;
        break;
      end
      waited++;
      if (waited > 50) begin
        total++;
        bad++;
        $display("FAIL beat_timeout: s_ready got 0 for 50 cycles, required 1");
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    sif.s_valid = 1'b0;
    sif.s_sof   = 1'b0;
    sif.s_eol   = 1'b0;
  endtask

  task automatic do_arm();
    @(negedge clk);
    sif.s_valid = 1'b0;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic send_frame(input bit rnd, input bit ff);
    int r, c;
    for (int n = 0; n < 4096; n++) begin
      r = n / 64;
      c = n % 64;
      if (rnd && ($urandom_range(0, 1) == 1)) idle();
      send_beat(ff ? 24'hFFFFFF : pix(r, c), n == 0, c == 63);
    end
  endtask

  task automatic test_reset();
    sif.s_valid = 1'b1;
    sif.s_data  = 24'h123456;
    sif.s_sof   = 1'b1;
    sif.s_eol   = 1'b0;
    #2;
    total++;
    if ({out_we, row, col, out_pix, load_done, frame_err, checksum} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got we=%0b row=%0d col=%0d pix=%h done=%0b err=%0b sum=%h, required all 0",
               out_we, row, col, out_pix, load_done, frame_err, checksum);
    end
    total++;
    if (sif.s_ready !== 1'b0 || state_dbg !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state: got ready=%0b state=%0d, required 0 and IDLE", sif.s_ready, state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (sif.s_ready !== 1'b0 || out_we !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_ready: got ready=%0b we=%0b, required 0 0", sif.s_ready, out_we);
    end
    idle();
  endtask

  task automatic test_full_frame();
    logic [31:0] exp_sum;
    exp_sum = '0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) exp_sum += {8'h0, pix(r, c)};
    clear_ram();
    do_arm();
    #1;
    total++;
    if (sif.s_ready !== 1'b1 || state_dbg !== ST_WAIT_SOF || load_done !== 1'b0) begin
      bad++;
      $display("FAIL armed: got ready=%0b state=%0d done=%0b, required 1 WAIT_SOF 0", sif.s_ready, state_dbg, load_done);
    end
    send_frame(0, 0);
    @(negedge clk);
    #1;
    total++;
    if (out_we !== 1'b1 || row !== 6'd63 || col !== 6'd63 || out_pix !== pix(63, 63) || load_done !== 1'b1) begin
      bad++;
      $display("FAIL last_write: got we=%0b row=%0d col=%0d pix=%h done=%0b, required 1 63 63 %h 1",
               out_we, row, col, out_pix, load_done, pix(63, 63));
    end
    total++;
`ifdef LOADER_CHECKSUM_EN
    if (checksum !== exp_sum) begin
`else
    if (checksum !== 32'h0) begin
`endif
      bad++;
      $display("FAIL frame_checksum: got %h, required %h (0 when disabled)", checksum, exp_sum);
    end
    idle();
    #1;
    total++;
    if (sif.s_ready !== 1'b0 || state_dbg !== ST_DONE || frame_err !== 1'b0 || out_we !== 1'b0) begin
      bad++;
      $display("FAIL done_state: got ready=%0b state=%0d err=%0b we=%0b, required 0 DONE 0 0",
               sif.s_ready, state_dbg, frame_err, out_we);
    end
    total++;
    if (ram_mismatches(0) !== 0 || wr_cnt !== 4096) begin
      bad++;
      $display("FAIL frame_ram: got %0d mismatches, %0d writes, required 0 and 4096", ram_mismatches(0), wr_cnt);
    end
  endtask

  task automatic test_random_valid();
    clear_ram();
    do_arm();
    send_frame(1, 0);
    idle();
    idle();
    total++;
    if (ram_mismatches(0) !== 0 || wr_cnt !== 4096 || load_done !== 1'b1) begin
      bad++;
      $display("FAIL random_ram: got %0d mismatches, %0d writes, done=%0b, required 0 4096 1",
               ram_mismatches(0), wr_cnt, load_done);
    end
    total++;
    if (spurious !== 0) begin
      bad++;
      $display("FAIL random_we: got %0d writes without a handshake, required 0", spurious);
    end
  endtask

  task automatic test_eol_error();
    clear_ram();
    do_arm();
    for (int n = 0; n < 202; n++) send_beat(pix(n / 64, n % 64), n == 0, (n % 64) == 63);
    send_beat(pix(3, 10), 1'b0, 1'b1);
    @(negedge clk);
    #1;
    total++;
    if (out_we !== 1'b0 || frame_err !== 1'b1 || state_dbg !== ST_ERR || wr_cnt !== 202) begin
      bad++;
      $display("FAIL eol_err: got we=%0b err=%0b state=%0d writes=%0d, required 0 1 ERR 202",
               out_we, frame_err, state_dbg, wr_cnt);
    end
    for (int k = 0; k < 3; k++) send_beat(24'hDEAD00 + 24'(k), 1'b0, 1'b0);
    idle();
    #1;
    total++;
    if (wr_cnt !== 202 || sif.s_ready !== 1'b1) begin
      bad++;
      $display("FAIL err_drop: got writes=%0d ready=%0b, required 202 1", wr_cnt, sif.s_ready);
    end
    clear_ram();
    send_frame(0, 0);
    idle();
    idle();
    total++;
    if (ram_mismatches(0) !== 0 || wr_cnt !== 4096 || load_done !== 1'b1 || frame_err !== 1'b1) begin
      bad++;
      $display("FAIL resync_frame: got %0d mismatches, %0d writes, done=%0b err=%0b, required 0 4096 1 1",
               ram_mismatches(0), wr_cnt, load_done, frame_err);
    end
  endtask

  task automatic test_arm_mid();
    clear_ram();
    do_arm();
    for (int n = 0; n < 2000; n++) send_beat(pix(n / 64, n % 64), n == 0, (n % 64) == 63);
    @(negedge clk);
    sif.s_valid = 1'b1;
    sif.s_data  = pix(31, 16);
    sif.s_sof   = 1'b0;
    sif.s_eol   = 1'b0;
    arm = 1'b1;
    #1;
    total++;
    if (sif.s_ready !== 1'b0) begin
      bad++;
      $display("FAIL arm_ready: got s_ready=%0b, required 0", sif.s_ready);
    end
    @(negedge clk);
    arm = 1'b0;
    #1;
    total++;
    if (out_we !== 1'b0 || state_dbg !== ST_WAIT_SOF || wr_cnt !== 2000 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL arm_state: got we=%0b state=%0d writes=%0d err=%0b, required 0 WAIT_SOF 2000 0",
               out_we, state_dbg, wr_cnt, frame_err);
    end
    for (int k = 0; k < 5; k++) send_beat(24'h111111 * 24'(k + 1), 1'b0, 1'b0);
    send_beat(24'hABCDEF, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    total++;
    if (wr_cnt !== 2001 || out_we !== 1'b1 || row !== 6'd0 || col !== 6'd0 || out_pix !== 24'hABCDEF) begin
      bad++;
      $display("FAIL arm_sof: got writes=%0d we=%0b row=%0d col=%0d pix=%h, required 2001 1 0 0 abcdef",
               wr_cnt, out_we, row, col, out_pix);
    end
    total++;
`ifdef LOADER_CHECKSUM_EN
    if (checksum !== 32'h00ABCDEF) begin
`else
    if (checksum !== 32'h0) begin
`endif
      bad++;
      $display("FAIL arm_checksum: got %h, required 00abcdef (0 when disabled)", checksum);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_arm();
    for (int n = 0; n < 1234; n++) send_beat(pix(n / 64, n % 64), n == 0, (n % 64) == 63);
    @(negedge clk);
    sif.s_valid = 1'b1;
    sif.s_data  = pix(19, 18);
    sif.s_sof   = 1'b0;
    sif.s_eol   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({out_we, row, col, out_pix, load_done, frame_err, checksum} !== '0 || sif.s_ready !== 1'b0 ||
        state_dbg !== ST_IDLE) begin
      bad++;
      $display("FAIL async_reset: got we=%0b row=%0d col=%0d pix=%h ready=%0b state=%0d, required all 0 IDLE",
               out_we, row, col, out_pix, sif.s_ready, state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (sif.s_ready !== 1'b0 || out_we !== 1'b0 || state_dbg !== ST_IDLE) begin
      bad++;
      $display("FAIL post_reset_idle: got ready=%0b we=%0b state=%0d, required 0 0 IDLE",
               sif.s_ready, out_we, state_dbg);
    end
    do_arm();
    #1;
    total++;
    if (sif.s_ready !== 1'b1) begin
      bad++;
      $display("FAIL rearm_ready: got s_ready=%0b, required 1", sif.s_ready);
    end
    idle();
  endtask

  task automatic test_checksum();
    clear_ram();
    do_arm();
    send_frame(0, 1);
    @(negedge clk);
    #1;
    total++;
`ifdef LOADER_CHECKSUM_EN
    if (checksum !== 32'hFFFFF000 || load_done !== 1'b1) begin
`else
    if (checksum !== 32'h0 || load_done !== 1'b1) begin
`endif
      bad++;
      $display("FAIL ff_checksum: got sum=%h done=%0b, required fffff000 (0 when disabled) and 1", checksum, load_done);
    end
    idle();
    total++;
    if (ram_mismatches(1) !== 0) begin
      bad++;
      $display("FAIL ff_ram: got %0d mismatches, required 0", ram_mismatches(1));
    end
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_sof   = 1'b0;
    sif.s_eol   = 1'b0;
    test_reset();
    test_full_frame();
    test_random_valid();
    test_eol_error();
    test_arm_mid();
    test_reset_mid();
    test_checksum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
